// File: rtl/v_pkg.sv
// Shared types and constants for the vector configuration controller.
// Encodings follow the RVV vtype layout: vsew in [5:3], vlmul in [2:0].
package v_pkg;

   typedef enum logic [1:0] {
      VSETVLI  = 2'b00,
      VSETIVLI = 2'b01,
      VSETVL   = 2'b10
   } cfg_op_e;

   typedef enum logic [2:0] {
      E8  = 3'b000,
      E16 = 3'b001,
      E32 = 3'b010,
      E64 = 3'b011
   } vsew_e;

   typedef enum logic [2:0] {
      M1  = 3'b000,
      M2  = 3'b001,
      M4  = 3'b010,
      M8  = 3'b011,
      MF8 = 3'b101,
      MF4 = 3'b110,
      MF2 = 3'b111
   } vlmul_e;

   localparam int unsigned VTYPE_VILL_BIT = 31;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      DRAIN  = 2'b01,
      CALC   = 2'b10,
      COMMIT = 2'b11
   } cfg_state_e;

endpackage

// File: rtl/v_vlmax_calc.sv
// Combinational VLMAX computation and vtype legality check for the low
// six vtype bits (vsew/vlmul) against the configured VLEN and ELEN.
module v_vlmax_calc
   import v_pkg::*;
#(
   parameter int VLEN = 256,
   parameter int ELEN = 64
) (
   input  logic [5:0]  vtype,
   output logic [31:0] vlmax,
   output logic        vill
);

   localparam logic [31:0] VLEN_W = 32'(VLEN);
   localparam logic [31:0] ELEN_W = 32'(ELEN);

   logic [2:0]  vsew;
   logic [2:0]  vlmul;
   logic [31:0] base;
   logic [31:0] sew;
   logic        lmul_bad;

   assign vsew  = vtype[5:3];
   assign vlmul = vtype[2:0];

   always_comb begin
      base     = VLEN_W >> (3 + vsew);
      sew      = 32'd8 << vsew;
      vlmax    = '0;
      lmul_bad = 1'b0;
      case (vlmul)
         M1:      vlmax = base;
         M2:      vlmax = base << 1;
         M4:      vlmax = base << 2;
         M8:      vlmax = base << 3;
         MF2:     vlmax = base >> 1;
         MF4:     vlmax = base >> 2;
         MF8:     vlmax = base >> 3;
         default: lmul_bad = 1'b1;
      endcase
      vill = lmul_bad | (vsew > E64) | (sew > ELEN_W) | (vlmax == '0);
   end

endmodule

// File: rtl/v_config_ctrl.sv
// Sequences vsetvli/vsetivli/vsetvl into the vl/vtype CSRs, draining
// in-flight vector ops first and stalling vector issue meanwhile.
module v_config_ctrl
   import v_pkg::*;
#(
   parameter int VLEN       = 256,
   parameter int ELEN       = 64,
   parameter int INFLIGHT_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [1:0]  cfg_op,
   input  logic [31:0] cfg_avl,
   input  logic [31:0] cfg_vtype,
   input  logic        cfg_rs1_x0,
   input  logic        cfg_rd_x0,
   input  logic [31:0] vl_cur,
   input  logic        vec_issue,
   input  logic        vec_done,
   output logic        issue_stall,
   output logic        csr_wr_en,
   output logic [31:0] csr_vl,
   output logic [31:0] csr_vtype,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        busy
);

   cfg_state_e state, state_n;

   logic [INFLIGHT_W-1:0] inflight;
   logic                  inflight_full;

   logic [1:0]  op_q;
   logic [31:0] avl_q;
   logic [31:0] vtype_q;
   logic        rs1_x0_q;
   logic        rd_x0_q;
   logic [31:0] vl_cur_q;

   logic [31:0] vlmax;
   logic        vill_fmt;
   logic        vill;
   logic [31:0] avl;
   logic [31:0] new_vl;
   logic [31:0] new_vtype;
   logic [31:0] new_vl_q;
   logic [31:0] new_vtype_q;

   assign inflight_full = &inflight;

   v_vlmax_calc #(
      .VLEN (VLEN),
      .ELEN (ELEN)
   ) u_vlmax_calc (
      .vtype (vtype_q[5:0]),
      .vlmax (vlmax),
      .vill  (vill_fmt)
   );

   always_comb begin
      vill = vill_fmt | (vtype_q[31:6] != '0) | (op_q == 2'b11);
      if (op_q == VSETIVLI)
         avl = {27'b0, avl_q[4:0]};
      else if (!rs1_x0_q)
         avl = avl_q;
      else if (!rd_x0_q)
         avl = '1;
      else
         avl = vl_cur_q;
      new_vl    = (avl <= vlmax) ? avl : vlmax;
      new_vtype = {26'b0, vtype_q[5:0]};
      if (vill) begin
         new_vl                    = '0;
         new_vtype                 = '0;
         new_vtype[VTYPE_VILL_BIT] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (cfg_valid) state_n = DRAIN;
         DRAIN:   if (inflight == '0) state_n = CALC;
         CALC:    state_n = COMMIT;
         COMMIT:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      cfg_ready   = (state == IDLE);
      busy        = (state != IDLE);
      csr_wr_en   = (state == COMMIT);
      rd_valid    = (state == COMMIT) && !rd_x0_q;
      issue_stall = (state != IDLE) || cfg_valid || inflight_full;
   end

   // Simultaneous issue and retire nets to zero regardless of the count.
   always_ff @(posedge clk) begin
      if (rst)
         inflight <= '0;
      else if (vec_issue && !vec_done && !inflight_full)
         inflight <= inflight + 1'b1;
      else if (vec_done && !vec_issue && (inflight != '0))
         inflight <= inflight - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q        <= '0;
         avl_q       <= '0;
         vtype_q     <= '0;
         rs1_x0_q    <= 1'b0;
         rd_x0_q     <= 1'b0;
         vl_cur_q    <= '0;
         new_vl_q    <= '0;
         new_vtype_q <= '0;
      end else begin
         if (state == IDLE && cfg_valid) begin
            op_q     <= cfg_op;
            avl_q    <= cfg_avl;
            vtype_q  <= cfg_vtype;
            rs1_x0_q <= cfg_rs1_x0;
            rd_x0_q  <= cfg_rd_x0;
            vl_cur_q <= vl_cur;
         end
         if (state == CALC) begin
            new_vl_q    <= new_vl;
            new_vtype_q <= new_vtype;
         end
      end
   end

   assign csr_vl    = new_vl_q;
   assign csr_vtype = new_vtype_q;
   assign rd_data   = new_vl_q;

endmodule

// File: doc/v_config_ctrl.md
Name: v_config_ctrl

Overview:
- Sequences vector configuration instructions (vsetvli, vsetivli, vsetvl) into the vector CSR block (vl/vtype registers with a single write-enable).
- Computes VLMAX and the new vl, and detects illegal vtype.
- Drains in-flight vector operations before committing, and stalls vector issue while a reconfiguration is pending.
- Sits between the decode/issue stage and the CSR block.

Parameters:
- VLEN, 256, vector register length in bits (power of 2, 64..4096).
- ELEN, 64, maximum supported element width in bits (32 or 64).
- INFLIGHT_W, 4, width of the in-flight vector-op counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cfg_valid  in  1  config request valid.
- cfg_ready  out  1  controller can accept a request.
- cfg_op  in  2  00 = vsetvli, 01 = vsetivli, 10 = vsetvl, 11 = reserved (treated as vill).
- cfg_avl  in  32  rs1 value, or uimm[4:0] zero-extended for vsetivli.
- cfg_vtype  in  32  zimm or rs2 value; [5:3] vsew, [2:0] vlmul.
- cfg_rs1_x0  in  1  rs1 field is x0 (ignored for vsetivli).
- cfg_rd_x0  in  1  rd field is x0.
- vl_cur  in  32  current vl from the CSR block.
- vec_issue  in  1  a vector op was issued this cycle.
- vec_done  in  1  a vector op retired this cycle.
- issue_stall  out  1  block vector issue.
- csr_wr_en  out  1  CSR write strobe.
- csr_vl  out  32  vl to write.
- csr_vtype  out  32  vtype to write.
- rd_valid  out  1  scalar writeback valid, one-cycle pulse.
- rd_data  out  32  new vl, for writeback to rd.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE, inflight = 0, all latched fields = 0.
  - csr_wr_en = 0, rd_valid = 0, csr_vl = 0, csr_vtype = 0, rd_data = 0.
  - cfg_ready = 1 and busy = 0 after reset.
  - Reset mid-operation aborts the request with no CSR write.
- FSM states are IDLE, DRAIN, CALC and COMMIT.
- IDLE:
  - cfg_ready = 1.
  - On cfg_valid, latch cfg_op, cfg_avl, cfg_vtype, cfg_rs1_x0, cfg_rd_x0 and vl_cur, then go to DRAIN.
- DRAIN:
  - Stay while inflight != 0.
  - When inflight == 0, go to CALC.
  - Minimum one cycle in DRAIN.
- CALC:
  - Register vlmax, vill, new_vl and new_vtype.
  - Go to COMMIT.
- COMMIT:
  - csr_wr_en = 1 and csr_vl/csr_vtype are valid for exactly this cycle.
  - rd_valid = 1 unless latched rd_x0.
  - Go to IDLE.
- Latency: request accepted at edge T0 with inflight = 0 gives csr_wr_en high during cycle T3. Each extra drain cycle adds 1. Back-to-back requests cost at least 4 cycles each.
- issue_stall = (state != IDLE) | (state == IDLE & cfg_valid) | (inflight == all-ones).
- inflight counter:
  - +1 on vec_issue, −1 on vec_done; both in the same cycle leaves it unchanged.
  - vec_done at 0 is ignored (saturates at 0).
  - vec_issue at max saturates; the upstream block must honour issue_stall.
- VLMAX:
  - base = VLEN >> (3 + vsew).
  - vlmul 000/001/010/011 shifts base left by 0/1/2/3.
  - vlmul 111/110/101 (mf2/mf4/mf8) shifts base right by 1/2/3.
- vill is set when any of the following holds:
  - vlmul == 100.
  - vsew > 011.
  - SEW (8 << vsew) > ELEN.
  - vlmax == 0.
  - cfg_vtype[31:6] != 0.
  - cfg_op == 11.
- AVL selection:
  - vsetivli: avl = cfg_avl[4:0].
  - Otherwise, if !rs1_x0: avl = cfg_avl.
  - If rs1_x0 & !rd_x0: avl = 0xFFFF_FFFF.
  - If rs1_x0 & rd_x0: avl = latched vl_cur.
- Result:
  - Legal: new_vl = (avl <= vlmax) ? avl : vlmax; new_vtype = {26'b0, cfg_vtype[5:0]}.
  - vill: new_vl = 0; new_vtype = 0x8000_0000.
- rd_data = new_vl, held until the next COMMIT.
- csr_vl and csr_vtype hold their last values outside COMMIT.

Decomposition:
- Shared package v_pkg:
  - cfg_op_e: VSETVLI, VSETIVLI, VSETVL.
  - vsew encodings E8..E64 and vlmul encodings M1..M8, MF2..MF8.
  - VTYPE_VILL_BIT = 31.
  - cfg_state_e: IDLE, DRAIN, CALC, COMMIT.
- Sub-module v_vlmax_calc (combinational): vtype[5:0] in, vlmax[31:0] and vill out, parameterised by VLEN and ELEN.

Test Plan:
- Legal clamp (VLEN = 256): vsetvli with avl = 5, vtype = 0x10 (e32 m1) → T3 csr_wr_en, csr_vl = 5, csr_vtype = 0x10, rd_data = 5. Then avl = 20 → csr_vl = 8.
- vsetivli uimm = 31, vtype = 0x03 (e8 m8, VLMAX 256) → csr_vl = 31. Then rs1_x0 = 1, rd_x0 = 0 → csr_vl = 256.
- Illegal vtype:
  - vtype = 0x04 (vlmul reserved) → csr_vtype = 0x8000_0000, csr_vl = 0, rd_data = 0.
  - vtype = 0x1D (e64 mf8, VLMAX 0) → same result.
- Drain: issue 2 vector ops, then request. Config stays in DRAIN with issue_stall = 1 until the second vec_done. csr_wr_en follows 2 cycles after inflight reaches 0.
- Keep-vl: vl_cur = 6, rs1_x0 = rd_x0 = 1, vtype = 0x10 → csr_vl = 6, rd_valid stays 0. With vl_cur = 12 → csr_vl = 8.
- Reset in CALC → no csr_wr_en, busy = 0, cfg_ready = 1 and inflight = 0 next cycle. A simultaneous issue and done at inflight = 1 leaves inflight = 1.
